// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
// Generates VGA raster timing (640x480@60 Hz with the default parameters) from
// the pixel clock. The asynchronous PLL lock indicator is synchronized and must
// stay high for LOCK_WAIT consecutive cycles before the raster starts. Losing
// lock returns the raster to idle at once; the count starts over from zero.
//
// Ports:
//   clk          pixel clock
//   rst          asynchronous, active-high reset
//   locked       PLL lock indicator, asynchronous to clk
//   hsync        horizontal sync, active low
//   vsync        vertical sync, active low
//   video_on     high while (x,y) lies in the visible area
//   x, y         current pixel column / line number
//   line_start   one-cycle pulse on x==0
//   frame_start  one-cycle pulse on x==0 and y==0
//
// Every output is a flop loaded from values decoded from the *next* x/y, so
// coordinates and flags always describe the same pixel on the same cycle.
// -----------------------------------------------------------------------------
module vga_timing #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int LOCK_WAIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CNT_W   = $clog2(LOCK_WAIT + 1);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_WAIT - 1);

    typedef enum logic [0:0] {
        WAIT_LOCK = 1'b0,
        RUN       = 1'b1
    } state_t;

    logic [1:0]       sync_r;
    logic             lk_s;
    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] lock_cnt_r;
    logic [CNT_W-1:0] lock_cnt_s;
    logic [9:0]       x_s;
    logic [9:0]       y_s;
    logic             hsync_s;
    logic             vsync_s;
    logic             video_on_s;
    logic             line_start_s;
    logic             frame_start_s;

    // Two-flop synchronizer bringing the PLL lock into the pixel clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], locked};
        end
    end

    assign lk_s = sync_r[1];

    // FSM state and lock-qualification counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= WAIT_LOCK;
            lock_cnt_r <= CNT_ZERO;
        end else begin
            state_r    <= state_s;
            lock_cnt_r <= lock_cnt_s;
        end
    end

    // Next state, next lock count and next raster position.
    // Outside RUN the position is forced to the origin so a restart begins at (0,0).
    always_comb begin
        state_s    = state_r;
        lock_cnt_s = lock_cnt_r;
        x_s        = 10'd0;
        y_s        = 10'd0;
        case (state_r)
            WAIT_LOCK: begin
                if (lk_s) begin
                    if (lock_cnt_r == LOCK_LAST) begin
                        state_s    = RUN;
                        lock_cnt_s = CNT_ZERO;
                    end else begin
                        lock_cnt_s = lock_cnt_r + CNT_ONE;
                    end
                end else begin
                    lock_cnt_s = CNT_ZERO;
                end
            end
            RUN: begin
                if (!lk_s) begin
                    state_s    = WAIT_LOCK;
                    lock_cnt_s = CNT_ZERO;
                end else if (x == H_LAST) begin
                    x_s = 10'd0;
                    if (y == V_LAST) begin
                        y_s = 10'd0;
                    end else begin
                        y_s = y + 10'd1;
                    end
                end else begin
                    x_s = x + 10'd1;
                    y_s = y;
                end
            end
            default: begin
                state_s    = WAIT_LOCK;
                lock_cnt_s = CNT_ZERO;
            end
        endcase
    end

    // Decode of the flags for the next pixel; idle levels whenever the next state is not RUN.
    always_comb begin
        hsync_s       = 1'b1;
        vsync_s       = 1'b1;
        video_on_s    = 1'b0;
        line_start_s  = 1'b0;
        frame_start_s = 1'b0;
        if (state_s == RUN) begin
            hsync_s       = !((x_s >= HS_BEGIN) && (x_s < HS_END));
            vsync_s       = !((y_s >= VS_BEGIN) && (y_s < VS_END));
            video_on_s    = (x_s < H_VIS) && (y_s < V_VIS);
            line_start_s  = (x_s == 10'd0);
            frame_start_s = (x_s == 10'd0) && (y_s == 10'd0);
        end else begin
            hsync_s       = 1'b1;
            vsync_s       = 1'b1;
            video_on_s    = 1'b0;
            line_start_s  = 1'b0;
            frame_start_s = 1'b0;
        end
    end

    // Output register stage: coordinates and flags load together, so there is no skew.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x           <= 10'd0;
            y           <= 10'd0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            x           <= x_s;
            y           <= y_s;
            hsync       <= hsync_s;
            vsync       <= vsync_s;
            video_on    <= video_on_s;
            line_start  <= line_start_s;
            frame_start <= frame_start_s;
        end
    end

endmodule
